// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver, with a first-word-fall-through read port, threshold and timeout interrupts, and sticky error flags.
// Optional build macro UART_RX_FIFO_FERR_TAG_EN stores each byte's frame-error bit alongside it and presents the head entry's bit on rd_ferr.
module uart_rx_fifo #(
  parameter int CLK_FREQ     = 125_000_000,
  parameter int BAUD         = 115200,
  parameter int DEPTH        = 16,
  parameter int TIMEOUT_BITS = 40,
  localparam int AW          = $clog2(DEPTH),
  localparam int LW          = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  output logic          rx_ack,
  input  logic          err_frame,
  input  logic          err_overrun,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_ferr,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level,
  input  logic [LW-1:0] thresh,
  output logic          irq_thresh,
  output logic          irq_timeout,
  output logic          err_frame_st,
  output logic          err_overrun_st,
  input  logic          clr_err
);

  localparam int          BIT_CLKS = CLK_FREQ / BAUD;
  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_BITS * BIT_CLKS - 1);

`ifdef UART_RX_FIFO_FERR_TAG_EN
  localparam int EW = 9;
`else
  localparam int EW = 8;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

  state_t        state, state_nxt;
  logic          wr, rd;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wdata, head;
  logic [AW-1:0] wptr, rptr;
  logic [31:0]   to_cnt;
  logic          frame_q, overrun_q;

  // ---------------- ingress FSM ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      rx_ack <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      state  <= state_nxt;
      rx_ack <= wr;
    end
  end

  always_comb begin
    // NOTE: defaulting every combinational output first prevents latch inference on unlisted paths.
    state_nxt = state;
    case (state)
      S_IDLE: if (rx_ready && !full) state_nxt = S_ACK;
      S_ACK:  state_nxt = S_HOLD;
      S_HOLD: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wr = (state == S_IDLE) && rx_ready && !full;
    rd = rd_en && !empty;
  end

  // ---------------- storage ----------------
`ifdef UART_RX_FIFO_FERR_TAG_EN
  assign wdata   = {err_frame, rx_data};
  assign rd_ferr = !empty && head[8];
`else
  assign wdata   = rx_data;
  assign rd_ferr = 1'b0;
`endif

  // NOTE: the storage array has no reset; level alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

  assign head    = mem[rptr];
  assign rd_data = head[7:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      case ({wr, rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign empty      = (level == '0);
  assign full       = (level == LW'(DEPTH));
  assign irq_thresh = (thresh != '0) && (level >= thresh);

  // ---------------- character timeout ----------------
  // Any traffic or an empty FIFO restarts the idle count; the count holds once it hits the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt      <= '0;
      irq_timeout <= 1'b0;
    end else if (wr || rd || empty) begin
      to_cnt      <= '0;
      irq_timeout <= 1'b0;
    end else if (to_cnt == TO_LIMIT) begin
      irq_timeout <= 1'b1;
    end else begin
      to_cnt <= to_cnt + 32'd1;
    end
  end

  // ---------------- sticky errors ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_q        <= 1'b0;
      overrun_q      <= 1'b0;
      err_frame_st   <= 1'b0;
      err_overrun_st <= 1'b0;
    end else begin
      frame_q        <= err_frame;
      overrun_q      <= err_overrun;
      err_frame_st   <= (err_frame && !frame_q) || (err_frame_st && !clr_err);
      err_overrun_st <= (err_overrun && !overrun_q) || (err_overrun_st && !clr_err);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based reference model compared every cycle, plus directed literal checks.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int LW    = 5;
  localparam int LIMIT = 640;   // 40 bit periods of 16 clocks

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_ready = 1'b0;
  logic          rx_ack;
  logic          err_frame = 1'b0;
  logic          err_overrun = 1'b0;
  logic          rd_en = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_ferr;
  logic          empty, full;
  logic [LW-1:0] level;
  logic [LW-1:0] thresh = '0;
  logic          irq_thresh, irq_timeout;
  logic          err_frame_st, err_overrun_st;
  logic          clr_err = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .DEPTH(DEPTH), .TIMEOUT_BITS(40)
  ) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_ready(rx_ready), .rx_ack(rx_ack),
    .err_frame(err_frame), .err_overrun(err_overrun), .rd_en(rd_en), .rd_data(rd_data),
    .rd_ferr(rd_ferr), .empty(empty), .full(full), .level(level), .thresh(thresh),
    .irq_thresh(irq_thresh), .irq_timeout(irq_timeout), .err_frame_st(err_frame_st),
    .err_overrun_st(err_overrun_st), .clr_err(clr_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Capture rule: receiver offers a byte, FIFO not full, and at least 3 clocks since the last capture.
  logic [8:0] q[$];
  int   cyc = 0;
  int   last_cap = -100;
  int   quiet = 0;
  bit   m_ack, m_fe, m_ov, p_fe, p_ov;
  bit   cap_now, rd_now, was_empty;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      last_cap = -100;
      quiet = 0;
      m_ack = 0; m_fe = 0; m_ov = 0; p_fe = 0; p_ov = 0;
    end else begin
      cyc++;
      was_empty = (q.size() == 0);
      rd_now    = rd_en && !was_empty;
      cap_now   = rx_ready && (q.size() < DEPTH) && (cyc - last_cap >= 3);
      m_ack     = cap_now;
      if (rd_now) void'(q.pop_front());
      if (cap_now) begin
        q.push_back({err_frame, rx_data});
        last_cap = cyc;
      end
      quiet = (cap_now || rd_now || was_empty) ? 0 : quiet + 1;
      m_fe  = (err_frame && !p_fe) || (m_fe && !clr_err);
      m_ov  = (err_overrun && !p_ov) || (m_ov && !clr_err);
      p_fe  = err_frame;
      p_ov  = err_overrun;
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      check("rx_ack", rx_ack, m_ack);
      check("level", level, q.size());
      check("empty", empty, q.size() == 0);
      check("full", full, q.size() == DEPTH);
      if (q.size() > 0) check("rd_data", rd_data, q[0][7:0]);
`ifdef UART_RX_FIFO_FERR_TAG_EN
      check("rd_ferr", rd_ferr, (q.size() > 0) ? q[0][8] : 1'b0);
`else
      check("rd_ferr", rd_ferr, 0);
`endif
      check("irq_thresh", irq_thresh, (thresh != 0) && (q.size() >= thresh));
      check("irq_timeout", irq_timeout, quiet >= LIMIT);
      check("err_frame_st", err_frame_st, m_fe);
      check("err_overrun_st", err_overrun_st, m_ov);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer one byte, wait for the capture, then hold rx_ready one extra clock like the lagging receiver.
  task automatic push(input logic [7:0] b);
    int start;
    bit got;
    start = last_cap;
    got = 0;
    rx_data  = b;
    rx_ready = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if (last_cap != start) got = 1;
    end
    check("push_accept", got, 1);
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic drain(input int n);
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    // ---- reset values ----
    repeat (3) tick();
    check("rst_ack", rx_ack, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_irq_thresh", irq_thresh, 0);
    check("rst_irq_timeout", irq_timeout, 0);
    check("rst_frame_st", err_frame_st, 0);
    check("rst_overrun_st", err_overrun_st, 0);
    check("rst_ferr", rd_ferr, 0);
    resetn = 1'b1;
    tick();

    // ---- single byte, stale rx_ready not re-acked ----
    rx_data = 8'hA5; rx_ready = 1'b1;
    tick();
    check("a5_ack", rx_ack, 1);
    check("a5_level", level, 1);
    check("a5_data", rd_data, 8'hA5);
    check("a5_empty", empty, 0);
    tick();
    check("a5_noack1", rx_ack, 0);
    tick();
    check("a5_noack2", rx_ack, 0);
    rx_ready = 1'b0;
    drain(1);
    check("a5_drained", empty, 1);

    // ---- fill, backpressure, readout order ----
    for (int i = 0; i < 16; i++) push(8'(i));
    check("fill_full", full, 1);
    check("fill_level", level, 16);
    rx_data = 8'h10; rx_ready = 1'b1;
    repeat (6) tick();
    check("fill_noack", rx_ack, 0);
    check("fill_head", rd_data, 8'h00);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("fill_rd_level", level, 15);
    check("fill_rd_noack", rx_ack, 0);
    tick();
    check("fill_late_ack", rx_ack, 1);
    check("fill_relevel", level, 16);
    tick();
    rx_ready = 1'b0;
    rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check("readout", rd_data, 32'(i));
      tick();
    end
    rd_en = 1'b0;
    check("readout_empty", empty, 1);

    // ---- simultaneous capture and read, pointer wrap ----
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
    repeat (2) tick();
    for (int i = 0; i < 40; i++) begin
      rx_data = 8'h80 + 8'(i); rx_ready = 1'b1; rd_en = 1'b1;
      tick();
      rx_ready = 1'b0; rd_en = 1'b0;
      check("simul_level", level, 5);
      repeat (2) tick();
    end
    check("simul_head", rd_data, 8'hA3);
    drain(5);
    check("simul_empty", empty, 1);

    // ---- threshold interrupt ----
    thresh = 5'd4;
    for (int i = 0; i < 3; i++) push(8'h20 + 8'(i));
    check("thr_below", irq_thresh, 0);
    push(8'h23);
    check("thr_at", irq_thresh, 1);
    drain(1);
    check("thr_fall", irq_thresh, 0);
    thresh = 5'd0;
    push(8'h24);
    push(8'h25);
    check("thr_zero", irq_thresh, 0);
    drain(5);

    // ---- character timeout ----
    repeat (700) tick();
    check("to_empty_idle", irq_timeout, 0);
    push(8'h77);
    n = 0;
    while (!irq_timeout && n < 1000) begin
      tick();
      n++;
    end
    check("to_latency", 32'(cyc - last_cap), LIMIT);
    drain(1);
    check("to_clear", irq_timeout, 0);

    // ---- sticky errors and frame tag ----
    err_frame = 1'b1;
    push(8'h3C);
    err_frame = 1'b0;
    push(8'h3D);
    check("fe_sticky", err_frame_st, 1);
    check("fe_head", rd_data, 8'h3C);
`ifdef UART_RX_FIFO_FERR_TAG_EN
    check("fe_tag_set", rd_ferr, 1);
`else
    check("fe_tag_off", rd_ferr, 0);
`endif
    drain(1);
    check("fe_tag_clr", rd_ferr, 0);
    err_overrun = 1'b1;
    tick();
    err_overrun = 1'b0;
    check("ov_sticky", err_overrun_st, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_fe", err_frame_st, 0);
    check("clr_ov", err_overrun_st, 0);
    err_frame = 1'b1; clr_err = 1'b1;
    tick();
    clr_err = 1'b0; err_frame = 1'b0;
    check("set_wins", err_frame_st, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_again", err_frame_st, 0);
    drain(1);
    rd_en = 1'b1;
    repeat (2) tick();
    rd_en = 1'b0;
    check("rd_empty_level", level, 0);

    // ---- reset mid-transfer ----
    push(8'h61);
    push(8'h62);
    rx_data = 8'h99; rx_ready = 1'b1;
    tick();
    resetn = 1'b0;
    tick();
    check("mid_rst_level", level, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_ack", rx_ack, 0);
    rx_ready = 1'b0;
    resetn = 1'b1;
    tick();
    push(8'h42);
    check("post_rst_data", rd_data, 8'h42);
    check("post_rst_level", level, 1);
    drain(1);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
